// File: rtl/alu_muldiv.sv
// Iterative MIPS-style multiply/divide unit with architectural HI/LO registers.
// Optional MULDIV_FAST_MUL_EN: single-cycle array multiply for MULT/MULTU.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIXUP,
        FAST
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;
    logic               neg_res;
    logic               rem_neg;
    logic               dbz_pend;

    logic               accept;
    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_raw;
    logic [2*WIDTH-1:0] fast_prod;
`endif

    assign in_ready = (state == IDLE);
    assign accept   = in_valid & (state == IDLE) & ~flush;

    always_comb begin
        is_signed = ~op[0];
        a_neg     = is_signed & A[WIDTH-1];
        b_neg     = is_signed & B[WIDTH-1];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;

        // Shift-add multiply step: {acc, shreg} holds partial product and multiplier.
        mul_sum   = {1'b0, acc} + (shreg[0] ? {1'b0, opnd} : '0);

        // Restoring divide step: acc is the partial remainder, shreg the dividend/quotient.
        div_shift = {acc, shreg[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_diff  = div_shift[WIDTH-1:0] - opnd;

        prod      = {acc, shreg};
        prod_s    = neg_res ? -prod : prod;
        // With a zero divisor acc ends up holding |A|, so re-signing it restores A.
        quo       = dbz_pend ? '1 : (neg_res ? -shreg : shreg);
        rem       = rem_neg ? -acc : acc;
`ifdef MULDIV_FAST_MUL_EN
        fast_raw  = {{WIDTH{1'b0}}, opnd} * {{WIDTH{1'b0}}, shreg};
        fast_prod = neg_res ? -fast_raw : fast_raw;
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            shreg       <= '0;
            opnd        <= '0;
            is_div      <= 1'b0;
            neg_res     <= 1'b0;
            rem_neg     <= 1'b0;
            dbz_pend    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            3'b100: hi <= A;
                            3'b101: lo <= A;
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                is_div   <= op[1];
                                neg_res  <= a_neg ^ b_neg;
                                rem_neg  <= a_neg;
                                dbz_pend <= op[1] & (B == '0);
                                acc      <= '0;
                                if (op[1]) begin
                                    opnd  <= b_mag;
                                    shreg <= a_mag;
                                end else begin
                                    opnd  <= a_mag;
                                    shreg <= b_mag;
                                end
                                cnt   <= CNT_W'(WIDTH);
                                state <= CALC;
`ifdef MULDIV_FAST_MUL_EN
                                if (!op[1]) begin
                                    cnt   <= '0;
                                    state <= FAST;
                                end
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        if (is_div) begin
                            acc   <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                            shreg <= {shreg[WIDTH-2:0], div_ge};
                        end else begin
                            acc   <= mul_sum[WIDTH:1];
                            shreg <= {mul_sum[0], shreg[WIDTH-1:1]};
                        end
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1))
                            state <= FIXUP;
                    end
                end
                FIXUP: begin
                    state <= IDLE;
                    if (!flush) begin
                        if (is_div) begin
                            hi <= rem;
                            lo <= quo;
                        end else begin
                            hi <= prod_s[2*WIDTH-1:WIDTH];
                            lo <= prod_s[WIDTH-1:0];
                        end
                        out_valid   <= 1'b1;
                        div_by_zero <= dbz_pend;
                    end
                end
`ifdef MULDIV_FAST_MUL_EN
                FAST: begin
                    state <= IDLE;
                    if (!flush) begin
                        hi          <= fast_prod[2*WIDTH-1:WIDTH];
                        lo          <= fast_prod[WIDTH-1:0];
                        out_valid   <= 1'b1;
                        div_by_zero <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed test-plan cases plus random ops vs. an arithmetic model.
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         flush;
    logic         out_valid;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .A           (A),
        .B           (B),
        .flush       (flush),
        .out_valid   (out_valid),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int lat_of(input logic [2:0] o);
`ifdef MULDIV_FAST_MUL_EN
        if (o[2:1] == 2'b00) return 1;
`endif
        return W + 1;
    endfunction

    // Reference: plain 64-bit integer arithmetic following the MIPS HI/LO rules.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el, output logic ed);
        longint          sa, sb, q, r;
        longint unsigned ua, ub;
        logic [63:0]     p, qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ed = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            3'd0: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            3'd1: begin p = ua * ub; eh = p[63:32]; el = p[31:0]; end
            default: begin
                if (b == '0) begin
                    el = '1;
                    eh = a;
                    ed = 1'b1;
                end else begin
                    if (o == 3'd2) begin
                        q = sa / sb;
                        r = sa % sb;
                    end else begin
                        q = longint'(ua / ub);
                        r = longint'(ua % ub);
                    end
                    qv = q;
                    rv = r;
                    el = qv[31:0];
                    eh = rv[31:0];
                end
            end
        endcase
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        op       = o;
        A        = a;
        B        = b;
        tick();
        in_valid = 1'b0;
        op       = 3'($urandom);
        A        = $urandom;
        B        = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic ed);
        int busy;
        busy = 0;
        issue(o, a, b);
        check({tag, "_pulse_end"}, 64'(out_valid), 64'd0);
        while (in_ready !== 1'b1 && busy < 100) begin
            busy++;
            tick();
        end
        check({tag, "_latency"}, 64'(busy), 64'(lat_of(o)));
        check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(ed));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]   o;
        logic [W-1:0] a, b, eh, el;
        logic         ed;
        int           pulses;

        resetn   = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        op       = '0;
        A        = '0;
        B        = '0;
        repeat (3) tick();
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        resetn = 1'b1;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);

        issue(3'b100, 32'h0000_AAAA, 32'h1);
        check("mthi_hi", 64'(hi), 64'h0000_AAAA);
        check("mthi_ready", 64'(in_ready), 64'd1);
        check("mthi_no_valid", 64'(out_valid), 64'd0);
        issue(3'b101, 32'h0000_5555, 32'h2);
        check("mtlo_lo", 64'(lo), 64'h0000_5555);
        check("mtlo_hi_kept", 64'(hi), 64'h0000_AAAA);
        issue(3'b110, 32'h1234_5678, 32'h9);
        issue(3'b111, 32'h8765_4321, 32'h9);
        check("nop_ready", 64'(in_ready), 64'd1);
        check("nop_hi", 64'(hi), 64'h0000_AAAA);
        check("nop_lo", 64'(lo), 64'h0000_5555);
        check("nop_no_valid", 64'(out_valid), 64'd0);

        // Directed cases run back-to-back: each request is issued in the previous out_valid cycle.
        run_op("mult_neg", 3'd0, 32'hFFFF_FFFE, 32'h3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("multu",    3'd1, 32'hFFFF_FFFE, 32'h3, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
        run_op("div_neg",  3'd2, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu",     3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("div_ovf",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
        run_op("divu_z",   3'd3, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        run_op("div_z_neg",3'd2, 32'hFFFF_FFF8, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);
        run_op("multu_max",3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_minsq",3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
        run_op("div_rem",  3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = '0;
                1: a = 32'h8000_0000;
                2: b = '1;
                3: b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            model(o, a, b, eh, el, ed);
            run_op("rand", o, a, b, eh, el, ed);
        end

        // Flush during CALC of a divide leaves HI/LO untouched.
        tick();
        issue(3'b100, 32'h0000_AAAA, 32'h0);
        issue(3'b101, 32'h0000_5555, 32'h0);
        issue(3'd2, 32'h0000_1000, 32'h3);
        repeat (9) tick();
        check("flush_busy", 64'(in_ready), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ready", 64'(in_ready), 64'd1);
        check("flush_hi", 64'(hi), 64'h0000_AAAA);
        check("flush_lo", 64'(lo), 64'h0000_5555);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) pulses++;
            tick();
        end
        check("flush_no_valid", 64'(pulses), 64'd0);
        check("flush_hi_later", 64'(hi), 64'h0000_AAAA);

        // Flush in IDLE blocks a same-edge request.
        flush = 1'b1;
        issue(3'b100, 32'h0000_1111, 32'h0);
        flush = 1'b0;
        check("idle_flush_hi", 64'(hi), 64'h0000_AAAA);
        check("idle_flush_ready", 64'(in_ready), 64'd1);

`ifdef MULDIV_FAST_MUL_EN
        issue(3'd1, 32'h0000_0003, 32'h0000_0005);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fast_flush_hi", 64'(hi), 64'h0000_AAAA);
        check("fast_flush_lo", 64'(lo), 64'h0000_5555);
        check("fast_flush_no_valid", 64'(out_valid), 64'd0);
        check("fast_flush_ready", 64'(in_ready), 64'd1);
`endif

        // Asynchronous reset in the middle of an operation.
`ifdef MULDIV_FAST_MUL_EN
        issue(3'd2, 32'h0000_7777, 32'h3);
`else
        issue(3'd0, 32'h0000_7777, 32'h3);
`endif
        repeat (5) tick();
        resetn = 1'b0;
        #1;
        check("async_rst_hi", 64'(hi), 64'd0);
        check("async_rst_lo", 64'(lo), 64'd0);
        check("async_rst_valid", 64'(out_valid), 64'd0);
        #2;
        resetn = 1'b1;
        tick();
        check("post_rst_ready", 64'(in_ready), 64'd1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) pulses++;
            tick();
        end
        check("post_rst_no_valid", 64'(pulses), 64'd0);

        run_op("post_rst_mult", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
        run_op("b2b_divu",      3'd3, 32'd1000, 32'd33, 32'd10, 32'd30, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised iterative multiply/divide unit that sits beside the combinational ALU in the EX stage.
- Executes MIPS-style MULT/MULTU/DIV/DIVU on WIDTH-bit operands and holds the results in architectural HI/LO registers.
- Also handles MTHI/MTLO writes.
- The pipeline stalls on in_ready low and cancels via flush on exceptions.

Parameters:
- WIDTH, 32: operand width, also HI/LO width; must be even and >= 8.
- CNT_W, $clog2(WIDTH)+1: iteration counter width. Derived; do not override.

Ports:
- clk, input, 1: clock, rising edge.
- resetn, input, 1: asynchronous active-low reset.
- in_valid, input, 1: operation request.
- in_ready, output, 1: unit can accept a request (state IDLE).
- op, input, 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- A, input, WIDTH: multiplicand / dividend / MTHI-MTLO source.
- B, input, WIDTH: multiplier / divisor.
- flush, input, 1: abort the in-flight operation.
- out_valid, output, 1: one-cycle pulse; HI/LO updated by a mul/div.
- hi, output, WIDTH: HI register.
- lo, output, WIDTH: LO register.
- div_by_zero, output, 1: sticky-for-one-result flag, valid with out_valid.

Behaviour:
- Reset (resetn low, asynchronous): state=IDLE; hi=0, lo=0, out_valid=0, div_by_zero=0, counter=0; in_ready=1 once released.
- Reset mid-operation discards all partial state.
- Accept: in_valid & in_ready at a rising edge.
- MTHI/MTLO: hi (or lo) <= A at the accept edge. Stays IDLE; no out_valid.
- Ops 110/111: accepted and ignored.
- MUL/DIV flow:
  - Latch |A|, |B| (magnitude for signed ops, raw for unsigned) plus sign bits; go to CALC with counter=WIDTH.
  - CALC: one radix-2 step per cycle (shift-add multiply; restoring divide). Counter decrements; on 1 -> FIXUP.
  - FIXUP: apply signs, then write hi/lo and go to IDLE.
  - out_valid=1 in the following cycle only.
- Latency: request accepted at edge N -> hi/lo new and out_valid high in the cycle after edge N+WIDTH+1. in_ready is low for exactly WIDTH+1 cycles.
- A new request may be accepted in the out_valid cycle. Back-to-back throughput is one op per WIDTH+2 cycles.
- Multiply result: {hi,lo} = 2*WIDTH-bit product. Signed product is negated if the operand signs differ.
- Divide result: lo = quotient, hi = remainder. Signed: quotient negative iff signs differ; remainder takes the dividend's sign (truncating division).
- Divide by zero (B==0, DIV/DIVU): still WIDTH+1 cycles. lo = all ones, hi = A (unmodified, original sign). div_by_zero=1 with out_valid.
- Signed overflow (DIV, A = most negative, B = -1): lo = most negative, hi = 0. No flag.
- Most-negative operand magnitude is handled in WIDTH+1 bits internally; no wrap error.
- flush high in CALC or FIXUP: next state IDLE. hi/lo unchanged; no out_valid.
- flush while IDLE: the same-edge request is not accepted (flush has priority).
- in_valid while busy: ignored. The requester must hold it.
- in_valid, op and operands are sampled only at accept.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU use a single-cycle array multiply. Request accepted at edge N -> hi/lo written at edge N+1; out_valid high the cycle after edge N+1; in_ready low for 1 cycle.
  - Divide is unchanged.
  - flush in that one cycle cancels the write.
- Undefined: all multiplies use the iterative WIDTH+1 cycle path.

Test Plan:
- MULT A=0xFFFFFFFE (-2), B=0x00000003 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFA, out_valid one cycle. MULTU same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU 100/7 -> lo=14, hi=2.
- DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0. DIVU A=0x1234, B=0 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1.
- Flush at CALC cycle 10 of DIV after MTHI 0xAAAA/MTLO 0x5555 -> hi=0xAAAA, lo=0x5555 unchanged, no out_valid, in_ready=1 next cycle.
- resetn pulsed low mid-MULT -> hi=lo=0 immediately (asynchronous), in_ready=1 after release; back-to-back request in the out_valid cycle is accepted.
- With MULDIV_FAST_MUL_EN defined: MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, in_ready low exactly 1 cycle.
